mul8_shiftadd: RTL and testbench

Iterative unsigned multiplier built around one addern instance. Each cycle it conditionally adds the multiplicand to the running partial product, then shifts right. It sits directly downstream of the adder and consumes its q/cout output every cycle. A start/busy/done handshake makes it the ALU's multi-cycle MUL unit.

---
 rtl/mul8_shiftadd.sv | 136 +++++++++++++
 tb/tb_mul8_shiftadd.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul8_shiftadd.sv
// Iterative unsigned shift-add multiplier (one adder, WIDTH passes).
// Ports: clk, rst, start, a, b -> busy, done, q[2*WIDTH-1:0].

// addern: N-bit adder with carry in/out.
//   i_a, i_b, i_cin -> o_q, o_cout
module addern #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_q,
  output logic         o_cout
);

  assign {o_cout, o_q} = {1'b0, i_a} + {1'b0, i_b}
                       + {{N{1'b0}}, i_cin};

endmodule

// mul8_shiftadd: start/busy/done multi-cycle MUL unit.
//   clk, rst(async, high), start, a, b -> busy, done, q
module mul8_shiftadd #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] q
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_q;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;

  assign w_addend = r_lo[0] ? r_mcand : '0;

  addern #(
    .N(WIDTH)
  ) u_add (
    .i_a   (r_hi),
    .i_b   (w_addend),
    .i_cin (1'b0),
    .o_q   (w_sum),
    .o_cout(w_cout)
  );

  // Carry becomes hi's MSB; sum LSB moves into lo as the
  // consumed multiplier bit shifts out.
  assign w_hi_nxt = {w_cout, w_sum[WIDTH-1:1]};
  assign w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand <= a;
            r_hi    <= '0;
            r_lo    <= b;
            r_cnt   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_q     <= {w_hi_nxt, w_lo_nxt};
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand <= a;
            r_hi    <= '0;
            r_lo    <= b;
            r_cnt   <= '0;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign q    = r_q;

endmodule

// File: tb/tb_mul8_shiftadd.sv
// Directed testbench for mul8_shiftadd.
// Hand-computed products, per-scenario tasks.
module tb_mul8_shiftadd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] q;

  int ncmp;
  int nerr;

  mul8_shiftadd #(
    .WIDTH(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      ncmp++;
      if (busy !== 1'b0 || done !== 1'b0 || q !== 16'h0000) begin
        nerr++;
        $display("FAIL reset_idle[%0d]: got busy=%b done=%b q=%h want 0 0 0000",
                 i, busy, done, q);
      end
    end
  endtask

  task automatic test_max;
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    ncmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      nerr++;
      $display("FAIL max_e0: got busy=%b done=%b want 1 0", busy, done);
    end
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      ncmp++;
      if (busy !== 1'b1 || done !== 1'b0 || q !== 16'h0000) begin
        nerr++;
        $display("FAIL max_run[E%0d]: got busy=%b done=%b q=%h want 1 0 0000",
                 k, busy, done, q);
      end
    end
    @(posedge clk);
    #1;
    ncmp++;
    if (busy !== 1'b0 || done !== 1'b1 || q !== 16'hFE01) begin
      nerr++;
      $display("FAIL max_e8: got busy=%b done=%b q=%h want 0 1 fe01",
               busy, done, q);
    end
    @(posedge clk);
    #1;
    ncmp++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== 16'hFE01) begin
      nerr++;
      $display("FAIL max_hold: got busy=%b done=%b q=%h want 0 0 fe01",
               busy, done, q);
    end
    idle_cycles(2);
  endtask

  task automatic test_values;
    logic [7:0]  va [3];
    logic [7:0]  vb [3];
    logic [15:0] vq [3];
    int          cyc;
    va[0] = 8'h0D; vb[0] = 8'h0B; vq[0] = 16'h008F;
    va[1] = 8'h00; vb[1] = 8'hA5; vq[1] = 16'h0000;
    va[2] = 8'h80; vb[2] = 8'h02; vq[2] = 16'h0100;
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      a     = va[v];
      b     = vb[v];
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = 8'h55;
      b     = 8'hAA;
      cyc   = 0;
      while (done !== 1'b1 && cyc < 20) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      ncmp++;
      if (cyc !== 8) begin
        nerr++;
        $display("FAIL vec%0d_latency: got %0d cycles want 8", v, cyc);
      end
      ncmp++;
      if (q !== vq[v]) begin
        nerr++;
        $display("FAIL vec%0d_q: got %h want %h", v, q, vq[v]);
      end
      idle_cycles(2);
    end
  endtask

  task automatic test_start_ignored;
    @(negedge clk);
    a     = 8'd3;
    b     = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    idle_cycles(2);
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ncmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      nerr++;
      $display("FAIL ign_e3: got busy=%b done=%b want 1 0", busy, done);
    end
    idle_cycles(4);
    ncmp++;
    if (busy !== 1'b1 || q !== 16'h0100) begin
      nerr++;
      $display("FAIL ign_e7: got busy=%b q=%h want 1 0100", busy, q);
    end
    @(posedge clk);
    #1;
    ncmp++;
    if (done !== 1'b1 || q !== 16'h000F) begin
      nerr++;
      $display("FAIL ign_e8: got done=%b q=%h want 1 000f", done, q);
    end
    @(posedge clk);
    #1;
    ncmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL ign_e9: got busy=%b done=%b want 0 0", busy, done);
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_abort;
    int cyc;
    int seen;
    @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    idle_cycles(4);
    #2;
    rst = 1'b1;
    #1;
    ncmp++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== 16'h0000) begin
      nerr++;
      $display("FAIL abort_now: got busy=%b done=%b q=%h want 0 0 0000",
               busy, done, q);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    ncmp++;
    if (seen !== 0) begin
      nerr++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", seen);
    end
    @(negedge clk);
    a     = 8'd2;
    b     = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    ncmp++;
    if (cyc !== 8 || q !== 16'h0006) begin
      nerr++;
      $display("FAIL abort_restart: got cyc=%0d q=%h want 8 0006", cyc, q);
    end
    idle_cycles(2);
  endtask

  task automatic test_back_to_back;
    logic exp_done;
    @(negedge clk);
    a     = 8'd7;
    b     = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 27; k++) begin
      @(posedge clk);
      #1;
      exp_done = ((k % 9) == 8);
      ncmp++;
      if (done !== exp_done || busy !== !exp_done) begin
        nerr++;
        $display("FAIL b2b_hs[E%0d]: got busy=%b done=%b want %b %b",
                 k, busy, done, !exp_done, exp_done);
      end
      if (exp_done) begin
        ncmp++;
        if (q !== 16'h003F) begin
          nerr++;
          $display("FAIL b2b_q[E%0d]: got %h want 003f", k, q);
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    idle_cycles(12);
    ncmp++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== 16'h003F) begin
      nerr++;
      $display("FAIL b2b_end: got busy=%b done=%b q=%h want 0 0 003f",
               busy, done, q);
    end
  endtask

  initial begin
    ncmp  = 0;
    nerr  = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    test_reset();
    test_max();
    test_values();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
